bcd_score_engine: RTL
=====================

Name: bcd_score_engine

Overview:
- Parametrised successor to the game score register: native BCD score counter with configurable digit count, hit prescaling, queued bonus points, saturation, and session high-score tracking.
- Drives 7-segment outputs for either the current score or the high score.
- Sits between the game-control FSM (start/hit/bonus/game_over pulses) and the board HEX displays.

Parameters:
- NUM_DIGITS, 6, number of BCD digits in score and high score (1..8).
- HITS_PER_POINT, 2, hit pulses required per 1 point (1..16).
- BONUS_W, 6, width of the binary bonus_amount input.
- BLANK_LEADING, 1, 1 = leading zero digits blanked on the display (digit 0 always shown).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears everything, including the high score.
- start  in  1  one-cycle pulse: clear score and begin play.
- hit  in  1  one-cycle pulse per correct tile.
- bonus_valid  in  1  qualifies bonus_amount.
- bonus_amount  in  BONUS_W  binary points to add.
- game_over  in  1  one-cycle pulse: end play and commit high score.
- show_high  in  1  display select: 1 = high score, 0 = score.
- score_bcd  out  4*NUM_DIGITS  current score, digit 0 in [3:0].
- high_bcd  out  4*NUM_DIGITS  session high score.
- busy  out  1  pending points not yet applied.
- saturated  out  1  score is all 9s.
- playing  out  1  FSM in PLAY.
- hex_segs  out  7*NUM_DIGITS  active-low segments; bit 0 = a … bit 6 = g, per digit, digit 0 lowest.

Behaviour:
- Reset (synchronous, active-high): state IDLE; score, high, pending, prescaler = 0; busy = 0; saturated = 0; playing = 0; hex_segs register = all-ones (all segments off).
- FSM states and transitions:
  - IDLE: start -> PLAY.
  - PLAY: game_over -> DONE; start -> PLAY (restart).
  - DONE: start -> PLAY.
  - Priority: reset > start > game_over.
- start (any state): score = 0, pending = 0, prescaler = 0, saturated = 0; high unchanged. No hit or bonus is counted in the start cycle.
- Hit prescaler (PLAY only):
  - A hit increments the prescaler.
  - When prescaler = HITS_PER_POINT-1, the prescaler wraps to 0 and 1 credit is generated.
  - With HITS_PER_POINT = 1, every hit is a credit.
- Pending counter:
  - Width BONUS_W+2 bits.
  - Each cycle: pending_next = pending + credit + (bonus_valid ? bonus_amount : 0) - drain.
  - Saturates at its all-ones value; never underflows.
  - Bonus is accepted in PLAY only, including while busy.
- Drain:
  - In PLAY, if pending > 0 and not saturated: score += 1 (BCD ripple carry, each digit 0..9) and drain = 1.
  - Throughput: 1 point per cycle. Latency from hit credit to score change: 1 cycle.
  - busy = (pending != 0), registered.
- Saturation: when an increment makes every digit 9, set saturated; pending is forced to 0 and all further credits and bonuses are discarded until start.
- game_over in PLAY:
  - No score change in that cycle; pending and prescaler cleared.
  - If score_bcd > high_bcd (unsigned compare of the packed BCD vector), high_bcd <= score_bcd in the same edge.
  - game_over outside PLAY is ignored.
- hit, bonus_valid, and game_over outside PLAY are ignored.
- Display path:
  - Source = show_high ? high_bcd : score_bcd.
  - Each digit decoded 0..9 to standard active-low patterns (e.g. 0 = 1000000, 1 = 1111001, 8 = 0000000).
  - With BLANK_LEADING, zero digits above the most significant nonzero digit output 1111111.
  - hex_segs is registered: 1-cycle latency from source or show_high change.

Test Plan:
- Reset mid-play (score 000042, high 000050, pending 3): assert reset 1 cycle -> next cycle all outputs 0, state IDLE, hex_segs all ones.
- HITS_PER_POINT=2: start, then 5 hit pulses on cycles 2,4,6,8,10 -> score 000001 after the 2nd hit +1 cycle, 000002 after the 4th; prescaler holds 1 after the 5th.
- Bonus 37 with score 000095 in PLAY -> busy for 37 cycles, score increments 1/cycle through 000099 -> 000100 (carry across 2 digits), final 000132, busy = 0.
- Simultaneous hit credit and bonus 4 in one cycle -> pending 5 applied; final score +5.
- NUM_DIGITS=2: score 97, bonus 10 -> score 99, saturated = 1, busy = 0 after 3 cycles; further hits leave 99; start clears both.
- game_over with score 000120, high 000100 -> high 000120 in the same edge; next game ends at 000080 -> high stays 000120. show_high=1 -> hex_segs shows 120 with digits 3..5 blanked, 1 cycle later.

Source files
------------

// File: rtl/bcd_score_engine.sv
`default_nettype none
// ============================================================================
// Module   : bcd_score_engine
// Brief    : Native-BCD game score counter with hit prescaling, queued bonus
//            points, saturation, session high score and 7-segment output.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_score_engine #(
    parameter int NUM_DIGITS     = 6,
    parameter int HITS_PER_POINT = 2,
    parameter int BONUS_W        = 6,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    hit,
    input  logic                    bonus_valid,
    input  logic [BONUS_W-1:0]      bonus_amount,
    input  logic                    game_over,
    input  logic                    show_high,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] high_bcd,
    output logic                    busy,
    output logic                    saturated,
    output logic                    playing,
    output logic [7*NUM_DIGITS-1:0] hex_segs
);

    localparam int c_SW     = 4 * NUM_DIGITS;
    localparam int c_HW     = 7 * NUM_DIGITS;
    localparam int c_PEND_W = BONUS_W + 2;
    localparam int c_PS_W   = (HITS_PER_POINT > 1) ? $clog2(HITS_PER_POINT) : 1;

    localparam logic [c_PEND_W-1:0] c_PEND_MAX = '1;
    localparam logic [c_PS_W-1:0]   c_PS_LAST  = c_PS_W'(HITS_PER_POINT - 1);
    localparam logic [c_SW-1:0]     c_ALL9     = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_SW-1:0]       r_score;
    logic [c_SW-1:0]       r_high;
    logic [c_PEND_W-1:0]   r_pending;
    logic [c_PS_W-1:0]     r_prescaler;
    logic                  r_busy;
    logic                  r_saturated;
    logic [c_HW-1:0]       r_hex;

    logic                  w_in_play;
    logic                  w_gover;
    logic                  w_active;
    logic                  w_hit;
    logic                  w_credit;
    logic                  w_drain;
    logic                  w_sat_now;
    logic [c_SW-1:0]       w_score_inc;
    logic [c_PEND_W:0]     w_bonus_ext;
    logic [c_PEND_W:0]     w_sum;
    logic [c_PEND_W-1:0]   w_pend_next;
    logic [c_PS_W-1:0]     w_ps_next;
    logic [c_SW-1:0]       w_src;
    logic [c_HW-1:0]       w_hex_next;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = PLAY;
        end else if (r_state == PLAY && game_over) begin
            w_state_next = DONE;
        end
    end

    // start pre-empts everything else in its cycle, game_over pre-empts scoring
    assign w_in_play = (r_state == PLAY) && !start;
    assign w_gover   = w_in_play && game_over;
    assign w_active  = w_in_play && !game_over;
    assign w_hit     = w_active && hit;
    assign w_credit  = w_hit && (r_prescaler == c_PS_LAST);
    assign w_drain   = w_active && (r_pending != '0) && !r_saturated;

    always_comb begin
        logic carry;
        carry       = 1'b1;
        w_score_inc = r_score;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    carry                 = 1'b0;
                end
            end
        end
    end

    assign w_sat_now   = w_drain && (w_score_inc == c_ALL9);
    assign w_bonus_ext = (w_active && bonus_valid) ? {3'b000, bonus_amount} : '0;
    // drain only happens with pending >= 1, so the subtraction cannot wrap
    assign w_sum       = {1'b0, r_pending} + {{c_PEND_W{1'b0}}, w_credit}
                       + w_bonus_ext - {{c_PEND_W{1'b0}}, w_drain};

    always_comb begin
        w_pend_next = r_pending;
        if (start || w_gover || r_saturated || w_sat_now) begin
            w_pend_next = '0;
        end else if (w_active) begin
            w_pend_next = w_sum[c_PEND_W] ? c_PEND_MAX : w_sum[c_PEND_W-1:0];
        end
    end

    always_comb begin
        w_ps_next = r_prescaler;
        if (start || w_gover) begin
            w_ps_next = '0;
        end else if (w_hit) begin
            w_ps_next = w_credit ? '0 : r_prescaler + c_PS_W'(1);
        end
    end

    assign w_src = show_high ? r_high : r_score;

    always_comb begin
        logic seen_nz;
        seen_nz    = 1'b0;
        w_hex_next = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (w_src[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            if (BLANK_LEADING == 0 || seen_nz || i == 0) begin
                w_hex_next[7*i +: 7] = seg7(w_src[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_score     <= '0;
            r_high      <= '0;
            r_pending   <= '0;
            r_prescaler <= '0;
            r_busy      <= 1'b0;
            r_saturated <= 1'b0;
            r_hex       <= '1;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pend_next;
            r_prescaler <= w_ps_next;
            r_busy      <= (w_pend_next != '0);
            r_hex       <= w_hex_next;
            if (start) begin
                r_score     <= '0;
                r_saturated <= 1'b0;
            end else begin
                if (w_drain) begin
                    r_score <= w_score_inc;
                end
                if (w_sat_now) begin
                    r_saturated <= 1'b1;
                end
            end
            // packed BCD orders the same as the decimal value it encodes
            if (w_gover && (r_score > r_high)) begin
                r_high <= r_score;
            end
        end
    end

    assign score_bcd = r_score;
    assign high_bcd  = r_high;
    assign busy      = r_busy;
    assign saturated = r_saturated;
    assign playing   = (r_state == PLAY);
    assign hex_segs  = r_hex;

endmodule
`default_nettype wire
